// File: rtl/fp_align_if.sv
// Handshake and result bundle for fp_align.
// The master side offers operands and consumes the aligned result; the slave side is the aligner.
interface fp_align_if;
   logic        IN_VALID;
   logic        in_ready;
   logic        MODE_FP;
   logic [31:0] OP_A;
   logic [31:0] OP_B;
   logic        out_valid;
   logic        OUT_READY;
   logic        sign_a;
   logic        sign_b;
   logic [22:0] mant_a;
   logic [22:0] mant_b;
   logic [8:0]  exp;
   logic        sticky_a;
   logic        sticky_b;
   logic        special;

   modport master (
      output IN_VALID, MODE_FP, OP_A, OP_B, OUT_READY,
      input  in_ready, out_valid, sign_a, sign_b, mant_a, mant_b, exp,
             sticky_a, sticky_b, special
   );

   modport slave (
      input  IN_VALID, MODE_FP, OP_A, OP_B, OUT_READY,
      output in_ready, out_valid, sign_a, sign_b, mant_a, mant_b, exp,
             sticky_a, sticky_b, special
   );
endinterface

// File: rtl/fp_align.sv
// Exponent alignment front end for a half/single FP add/sub stage.
// The smaller-exponent significand is shifted right one bit per cycle, with sticky collection.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CMP   | fields extracted, exponents compared, shift distance chosen
// SHIFT | one right shift of the target significand per cycle
// DONE  | result held with out_valid high until OUT_READY
module fp_align (
   input logic CLK,
   input logic RST,
   fp_align_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

   state_t      state_q, state_nxt;
   logic [31:0] op_a_q, op_a_nxt, op_b_q, op_b_nxt;
   logic        mode_q, mode_nxt;
   logic        sign_a_q, sign_a_nxt, sign_b_q, sign_b_nxt;
   logic [22:0] mant_a_q, mant_a_nxt, mant_b_q, mant_b_nxt;
   logic [8:0]  exp_q, exp_nxt;
   logic        sticky_a_q, sticky_a_nxt, sticky_b_q, sticky_b_nxt;
   logic        special_q, special_nxt;
   logic        shift_a_q, shift_a_nxt;
   logic [4:0]  cnt_q, cnt_nxt;

   logic        sg_a, sg_b, inf_a, inf_b, s0_a, s0_b, a_small;
   logic [8:0]  ef_a, ef_b, ee_a, ee_b, diff, exp_max;
   logic [22:0] m0_a, m0_b;

   // Inf/NaN get no hidden bit so the raw fraction (NaN payload) passes through.
   always_comb begin
      if (mode_q) begin
         sg_a  = op_a_q[31];
         ef_a  = {1'b0, op_a_q[30:23]};
         inf_a = &op_a_q[30:23];
         m0_a  = {((op_a_q[30:23] != 8'd0) && !inf_a), op_a_q[22:1]};
         s0_a  = op_a_q[0];
         sg_b  = op_b_q[31];
         ef_b  = {1'b0, op_b_q[30:23]};
         inf_b = &op_b_q[30:23];
         m0_b  = {((op_b_q[30:23] != 8'd0) && !inf_b), op_b_q[22:1]};
         s0_b  = op_b_q[0];
      end else begin
         sg_a  = op_a_q[15];
         ef_a  = {4'b0, op_a_q[14:10]};
         inf_a = &op_a_q[14:10];
         m0_a  = {12'b0, ((op_a_q[14:10] != 5'd0) && !inf_a), op_a_q[9:0]};
         s0_a  = 1'b0;
         sg_b  = op_b_q[15];
         ef_b  = {4'b0, op_b_q[14:10]};
         inf_b = &op_b_q[14:10];
         m0_b  = {12'b0, ((op_b_q[14:10] != 5'd0) && !inf_b), op_b_q[9:0]};
         s0_b  = 1'b0;
      end
      ee_a    = (ef_a == 9'd0) ? 9'd1 : ef_a;
      ee_b    = (ef_b == 9'd0) ? 9'd1 : ef_b;
      a_small = (ee_a < ee_b);
      diff    = a_small ? (ee_b - ee_a) : (ee_a - ee_b);
      exp_max = a_small ? ee_b : ee_a;
   end

   always_comb begin
      state_nxt    = state_q;
      op_a_nxt     = op_a_q;
      op_b_nxt     = op_b_q;
      mode_nxt     = mode_q;
      sign_a_nxt   = sign_a_q;
      sign_b_nxt   = sign_b_q;
      mant_a_nxt   = mant_a_q;
      mant_b_nxt   = mant_b_q;
      exp_nxt      = exp_q;
      sticky_a_nxt = sticky_a_q;
      sticky_b_nxt = sticky_b_q;
      special_nxt  = special_q;
      shift_a_nxt  = shift_a_q;
      cnt_nxt      = cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.IN_VALID) begin
               op_a_nxt  = bus.OP_A;
               op_b_nxt  = bus.OP_B;
               mode_nxt  = bus.MODE_FP;
               state_nxt = CMP;
            end
         end
         CMP: begin
            sign_a_nxt   = sg_a;
            sign_b_nxt   = sg_b;
            mant_a_nxt   = m0_a;
            mant_b_nxt   = m0_b;
            sticky_a_nxt = s0_a;
            sticky_b_nxt = s0_b;
            special_nxt  = 1'b0;
            shift_a_nxt  = a_small;
            if (inf_a || inf_b) begin
               special_nxt = 1'b1;
               exp_nxt     = mode_q ? 9'd255 : 9'd31;
               state_nxt   = DONE;
            end else begin
               exp_nxt = exp_max;
               if (diff == 9'd0) begin
                  state_nxt = DONE;
               end else if (diff >= 9'd24) begin
                  if (a_small) begin
                     mant_a_nxt   = 23'd0;
                     sticky_a_nxt = s0_a | (m0_a != 23'd0);
                  end else begin
                     mant_b_nxt   = 23'd0;
                     sticky_b_nxt = s0_b | (m0_b != 23'd0);
                  end
                  state_nxt = DONE;
               end else begin
                  cnt_nxt   = diff[4:0];
                  state_nxt = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (shift_a_q) begin
               mant_a_nxt   = mant_a_q >> 1;
               sticky_a_nxt = sticky_a_q | mant_a_q[0];
            end else begin
               mant_b_nxt   = mant_b_q >> 1;
               sticky_b_nxt = sticky_b_q | mant_b_q[0];
            end
            cnt_nxt = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_nxt = DONE;
         end
         DONE: begin
            if (bus.OUT_READY) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         op_a_q     <= 32'd0;
         op_b_q     <= 32'd0;
         mode_q     <= 1'b0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         mant_a_q   <= 23'd0;
         mant_b_q   <= 23'd0;
         exp_q      <= 9'd0;
         sticky_a_q <= 1'b0;
         sticky_b_q <= 1'b0;
         special_q  <= 1'b0;
         shift_a_q  <= 1'b0;
         cnt_q      <= 5'd0;
      end else begin
         state_q    <= state_nxt;
         op_a_q     <= op_a_nxt;
         op_b_q     <= op_b_nxt;
         mode_q     <= mode_nxt;
         sign_a_q   <= sign_a_nxt;
         sign_b_q   <= sign_b_nxt;
         mant_a_q   <= mant_a_nxt;
         mant_b_q   <= mant_b_nxt;
         exp_q      <= exp_nxt;
         sticky_a_q <= sticky_a_nxt;
         sticky_b_q <= sticky_b_nxt;
         special_q  <= special_nxt;
         shift_a_q  <= shift_a_nxt;
         cnt_q      <= cnt_nxt;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sign_a    = sign_a_q;
   assign bus.sign_b    = sign_b_q;
   assign bus.mant_a    = mant_a_q;
   assign bus.mant_b    = mant_b_q;
   assign bus.exp       = exp_q;
   assign bus.sticky_a  = sticky_a_q;
   assign bus.sticky_b  = sticky_b_q;
   assign bus.special   = special_q;

endmodule

// File: doc/fp_align.md
FP_ALIGN -- requirements
Module: fp_align

Interface
REQ-001 SHALL have parameters: none; all widths are fixed.
REQ-002 SHALL have ports:
- CLK, input, 1 bit: the only clock; all state updates on its rising edge.
- RST, input, 1 bit: reset, asynchronous, active-high.
- IN_VALID, input, 1 bit: an operand pair is offered.
- in_ready, output, 1 bit: the block accepts operands; high only in IDLE.
- MODE_FP, input, 1 bit: 0 = half, 1 = single; latched at accept.
- OP_A / OP_B, input, 32 bits each: raw IEEE operands; half mode uses [15:0] only.
- out_valid, output, 1 bit: aligned result held valid.
- OUT_READY, input, 1 bit: downstream add/sub stage accepts the result.
- sign_a / sign_b, output, 1 bit each: operand signs.
- mant_a / mant_b, output, 23 bits each: aligned significands.
- exp, output, 9 bits: common exponent.
- sticky_a / sticky_b, output, 1 bit each: OR of all bits discarded from that significand.
- special, output, 1 bit: either operand is Inf or NaN.

Function
REQ-003 SHALL implement a state machine with states IDLE, CMP, SHIFT and DONE.
REQ-004 IDLE SHALL accept on IN_VALID&&in_ready: latch OP_A, OP_B and MODE_FP, then go to CMP; IN_VALID outside IDLE SHALL be ignored.
REQ-005 Field extraction, single mode: sign = bit 31; exponent field = [30:23]; fraction = [22:0].
REQ-006 Field extraction, half mode: sign = bit 15; exponent field = [14:10]; fraction = [9:0]; exponent zero-extended to 9 bits.
REQ-007 Significand format, single mode: mant = {hidden, frac[22:1]}; frac[0] SHALL initialise that operand's sticky bit.
REQ-008 Significand format, half mode: mant = {12'b0, hidden, frac[9:0]}; sticky SHALL initialise to 0.
REQ-009 Hidden bit SHALL be 1 for a nonzero exponent field; for a zero field, hidden = 0 and the effective exponent SHALL be 1 (denormal/zero).
REQ-010 Special case in CMP: if either exponent field is all-ones, the block SHALL set special = 1, exp = 255 (single) or 31 (half), pass both significands unshifted, and go to DONE.
REQ-011 Otherwise CMP SHALL set exp = max(effective exponents) and d = |EA-EB|; the operand with the smaller exponent is the shift target, and A/B positions SHALL never be swapped.
REQ-012 From CMP:
- d == 0: go to DONE.
- d >= 24: set the target significand to 0, set its sticky |= (significand != 0), go to DONE.
- 1 <= d <= 23: load counter = d, go to SHIFT.
REQ-013 SHIFT SHALL do, each cycle: target mant >>= 1; its sticky |= shifted-out LSB; counter decrements.
REQ-014 SHIFT SHALL go to DONE in the cycle the counter reaches 0, so exactly d shifts occur.
REQ-015 Latency: counting the accept edge as cycle 0, out_valid SHALL first be high in cycle 2 when there is no shift, and in cycle 2+d when 1 <= d <= 23.
REQ-016 In DONE, out_valid SHALL be 1 and all outputs SHALL hold stable until OUT_READY=1; that edge SHALL return to IDLE with out_valid = 0.
REQ-017 There is no pass-through: the next accept is at the earliest one cycle after the DONE handshake.
REQ-018 Output fields SHALL be registered and SHALL change only in CMP and SHIFT.

Reset
REQ-019 RST=1 SHALL immediately force the state to IDLE, regardless of clock, and clear:
- out_valid, special, sticky_a, sticky_b;
- sign_a, sign_b, mant_a, mant_b, exp;
- the counter.
REQ-020 in_ready SHALL be 1 while in reset-released IDLE.
REQ-021 RST asserted mid-operation (CMP, SHIFT or DONE) SHALL abort with no output handshake; operation SHALL resume at the first CLK edge after RST falls.

Verification
REQ-022 Single, 0x3F800000 (A) and 0x40000000 (B): d=1 -> exp=128, mant_a=0x200000, mant_b=0x400000, stickies 0, out_valid in cycle 3.
REQ-023 Half, 0x3C00 and 0x3C00: d=0 -> exp=15, mant_a=mant_b=0x000400, out_valid in cycle 2.
REQ-024 Single, 0x4B800000 and 0x3F800001: d=24 -> exp=151, mant_b=0, sticky_b=1, mant_a=0x400000, out_valid in cycle 2.
REQ-025 Single, 0x7F800000 and 0x3F800000 -> special=1, exp=255, mant_a=0, mant_b=0x400000, out_valid in cycle 2.
REQ-026 Back-pressure: hold OUT_READY=0 for 5 cycles in DONE -> outputs constant, in_ready=0, a new IN_VALID is ignored; OUT_READY=1 -> IDLE next cycle.
REQ-027 Reset abort: assert RST during SHIFT of a d=10 operation -> out_valid=0 and state IDLE without a clock edge; a new operand pair is accepted after RST falls.
